apb_periph_bridge: RTL

- Memory-stage APB master for the pipelined RV32I core. Converts one load or store to a peripheral address into a single APB transfer.
- Generates the completion handshake that the hazard unit uses to stall and release the pipeline: trans_done, store_done, store_finished.
- Sits between the MEM stage / peripheral address decoder and the APB bus (UART slave and others).

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_wait_timer.sv | 30 +++
 rtl/apb_periph_bridge.sv | 128 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the MEM-stage APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

  localparam logic [3:0] PERIPH_NONE  = 4'd0;
  localparam logic [3:0] PERIPH_GPIO  = 4'd1;
  localparam logic [3:0] PERIPH_UART  = 4'd2;
  localparam logic [3:0] PERIPH_TIMER = 4'd3;

  // Peripheral code whose accesses hold the pipeline until completion.
  localparam logic [3:0] UART_SEL = PERIPH_UART;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating PREADY wait counter; timeout fires on the cycle the count would reach MAX.
module apb_wait_timer #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int CNT_W = (MAX == 0) ? 1 : $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((MAX == 0) ? 0 : MAX - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // MAX of zero leaves the counter running but never reports a timeout.
  assign timeout = (MAX != 0) && en && (cnt == LAST);

endmodule

// File: rtl/apb_periph_bridge.sv
// MEM-stage APB master: one load/store to a peripheral becomes one APB transfer,
// with completion strobes for the hazard unit.
//
// state  | meaning
// IDLE   | waiting for transEn with a non-zero peripheral select
// SETUP  | APB setup phase, PSEL only
// ACCESS | PSEL+PENABLE, waiting for PREADY or timeout
// DONE   | completion cycle, pipeline advances at its end
module apb_periph_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              transEn,
  input  logic [3:0]        peripheral_load,
  input  logic              opcode5,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              trans_done,
  output logic              store_done,
  output logic              store_finished,
  output logic              bus_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e state, state_nxt;
  logic       req;
  logic       tmr_clr, tmr_en, tmr_tc;
  logic       err_q;

  assign req     = transEn && (peripheral_load != PERIPH_NONE);
  assign tmr_clr = (state == IDLE) && req;
  assign tmr_en  = (state == ACCESS) && !PREADY;

  apb_wait_timer #(.MAX(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .timeout(tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || tmr_tc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data/direction only move on acceptance, so they hold through SETUP and ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
      rdata  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (tmr_clr) begin
        PADDR  <= addr;
        PWDATA <= wdata;
        PWRITE <= opcode5;
      end
      if (state == ACCESS) begin
        if (PREADY) begin
          err_q <= PSLVERR;
          if (!PWRITE) rdata <= PRDATA;
        end else if (tmr_tc) begin
          err_q <= 1'b1;
          if (!PWRITE) rdata <= '0;
        end
      end
    end
  end

  always_comb begin
    PSEL           = 1'b0;
    PENABLE        = 1'b0;
    trans_done     = 1'b0;
    bus_err        = 1'b0;
    store_done     = 1'b0;
    store_finished = 1'b0;
    case (state)
      IDLE: store_done = req && opcode5;
      SETUP: begin
        PSEL       = 1'b1;
        store_done = PWRITE;
      end
      ACCESS: begin
        PSEL       = 1'b1;
        PENABLE    = 1'b1;
        store_done = PWRITE;
      end
      DONE: begin
        trans_done     = 1'b1;
        bus_err        = err_q;
        store_done     = PWRITE;
        store_finished = PWRITE;
      end
      default: ;
    endcase
  end

endmodule
